decimal_to_binary_encoder: RTL and testbench
============================================

// Module: decimal_to_binary_encoder
// PURPOSE
//   Converts a packed-BCD decimal value (DIGITS digits, 4 bits each) to plain unsigned binary.
//   The default single-digit build maps decimal 0..9 to the identical 4-bit binary code 0000..1001.
//   It is a registered datapath stage with a valid strobe and an invalid-digit error flag.
//   It sits between decimal-entry/display logic and binary arithmetic blocks.
// PARAMETERS
//   DIGITS  1  number of BCD digits on the input; legal range 1..4
//   BIN_W   (derived localparam) output width: DIGITS=1->4, 2->7, 3->10, 4->14
// PORTS
//   clk        in   1          rising-edge clock; the only clock
//   rst        in   1          synchronous, active-high reset
//   in_valid   in   1          decimal is valid this cycle
//   decimal    in   4*DIGITS   packed BCD; digit 0 (units) in bits [3:0]
//   out_valid  out  1          binary/err are valid this cycle
//   binary     out  BIN_W      unsigned binary equivalent of decimal
//   err        out  1          at least one input digit was > 9 (codes 1010..1111)
//   err_sticky out  1          set by any err; cleared only by rst
// BEHAVIOUR
//   - Single clock domain. All outputs are registered. Reset is synchronous and active-high.
//   - Reset: when rst=1 at a rising edge, out_valid=0, binary=0, err=0 and err_sticky=0.
//     While rst is held, in_valid is ignored. rst has priority over every other event.
//   - Latency is 1 cycle. An input sampled with in_valid=1 at edge N appears on the outputs
//     after edge N, together with out_valid=1.
//   - in_valid=0 at an edge: out_valid=0 next cycle. binary and err hold their previous values.
//   - Conversion: binary = sum over k of digit[k] * 10^k, computed as unsigned with no overflow.
//     BIN_W is sized to hold 10^DIGITS - 1.
//   - Single digit (DIGITS=1): binary = decimal for inputs 0..9 (0->0000, 5->0101, 9->1001).
//   - Invalid digit: if any digit is >= 10 on a valid input:
//       err=1, binary=0, out_valid=1 (the item is still reported), and err_sticky becomes 1.
//   - Valid-only input: err=0 on that output cycle; err_sticky keeps its value.
//   - Back-to-back inputs: one result per cycle at full throughput, no stall and no backpressure.
//   - Reset mid-stream: an item sampled at the same edge as rst=1 is discarded, so no out_valid.
//   - No latches. No combinational path from any input to any output.
// TESTING
//   - Reset: drive rst=1 for 2 cycles -> out_valid=0, binary=0, err=0, err_sticky=0.
//   - DIGITS=1 sweep: decimal=0..9, one per cycle, in_valid=1 -> binary 0..9 one cycle later,
//     err=0, out_valid=1 each cycle.
//   - Invalid: decimal=4'b1010 then 4'b1111 -> binary=0, err=1 and err_sticky=1;
//     a following decimal=3 -> binary=3, err=0, err_sticky stays 1.
//   - Gaps: pulse in_valid with decimal=7, then hold in_valid=0 while decimal toggles
//     -> a single out_valid pulse, and binary holds 0111.
//   - DIGITS=2: decimal=8'h99 -> binary=99 (7'b1100011); 8'h10 -> 10; 8'h3A -> err=1.
//   - Reset mid-stream: assert rst at the same edge as in_valid=1 with decimal=6
//     -> no out_valid, outputs return to their reset values.

Source files
------------

// File: rtl/decimal_to_binary_encoder.sv
// Registered packed-BCD to unsigned binary converter with per-item and sticky invalid-digit flags.
// One result per accepted input, one cycle later; no backpressure.
module decimal_to_binary_encoder #(
   parameter int DIGITS = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [4*DIGITS-1:0]   decimal,
   output logic                  out_valid,
   output logic [((DIGITS == 1) ? 4 : (DIGITS == 2) ? 7 : (DIGITS == 3) ? 10 : 14)-1:0] binary,
   output logic                  err,
   output logic                  err_sticky
);

   localparam int BIN_W = (DIGITS == 1) ? 4 : (DIGITS == 2) ? 7 : (DIGITS == 3) ? 10 : 14;

   // Handshake: valid-only. An input is accepted on every rising edge where in_valid=1
   // and rst=0; its result is presented with out_valid=1 for exactly the following cycle.
   // There is no ready signal, so the source may issue a new item every cycle.

   logic [BIN_W-1:0] conv;
   logic             bad_digit;
   logic [3:0]       digit;

   // Horner evaluation from the most significant digit keeps every partial sum
   // below 10^DIGITS, so the BIN_W-wide accumulator never overflows.
   always_comb begin
      conv      = '0;
      bad_digit = 1'b0;
      digit     = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         digit = decimal[4*k +: 4];
         if (digit > 4'd9)
            bad_digit = 1'b1;
         conv = conv * BIN_W'(10) + BIN_W'(digit);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         binary     <= '0;
         err        <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            err    <= bad_digit;
            binary <= bad_digit ? '0 : conv;
            if (bad_digit)
               err_sticky <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_decimal_to_binary_encoder.sv
// Directed bench for decimal_to_binary_encoder: one-digit and two-digit builds side by side.
module tb_decimal_to_binary_encoder;

   logic       clk;
   logic       rst;

   logic       in_valid1;
   logic [3:0] decimal1;
   logic       out_valid1;
   logic [3:0] binary1;
   logic       err1;
   logic       err_sticky1;

   logic       in_valid2;
   logic [7:0] decimal2;
   logic       out_valid2;
   logic [6:0] binary2;
   logic       err2;
   logic       err_sticky2;

   int test_count;
   int fail_count;

   decimal_to_binary_encoder #(.DIGITS(1)) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid1),
      .decimal    (decimal1),
      .out_valid  (out_valid1),
      .binary     (binary1),
      .err        (err1),
      .err_sticky (err_sticky1)
   );

   decimal_to_binary_encoder #(.DIGITS(2)) u_dut2 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid2),
      .decimal    (decimal2),
      .out_valid  (out_valid2),
      .binary     (binary2),
      .err        (err2),
      .err_sticky (err_sticky2)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      test_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // advance past the next rising edge and settle
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic v, input logic [3:0] d);
      in_valid1 = v;
      decimal1  = d;
      tick();
   endtask

   task automatic drive2(input logic v, input logic [7:0] d);
      in_valid2 = v;
      decimal2  = d;
      tick();
   endtask

   task automatic check1(input string tag, input logic ov, input logic [3:0] b,
                         input logic e, input logic es);
      check({tag, ".out_valid"},  out_valid1,  ov);
      check({tag, ".binary"},     binary1,     b);
      check({tag, ".err"},        err1,        e);
      check({tag, ".err_sticky"}, err_sticky1, es);
   endtask

   task automatic check2(input string tag, input logic ov, input logic [6:0] b,
                         input logic e, input logic es);
      check({tag, ".out_valid"},  out_valid2,  ov);
      check({tag, ".binary"},     binary2,     b);
      check({tag, ".err"},        err2,        e);
      check({tag, ".err_sticky"}, err_sticky2, es);
   endtask

   initial begin
      test_count = 0;
      fail_count = 0;
      rst        = 1'b1;
      in_valid1  = 1'b1;   // must be ignored while rst is held
      decimal1   = 4'd5;
      in_valid2  = 1'b1;
      decimal2   = 8'h42;

      // reset held for two cycles
      tick();
      tick();
      check1("reset1", 1'b0, 4'd0, 1'b0, 1'b0);
      check2("reset2", 1'b0, 7'd0, 1'b0, 1'b0);
      rst       = 1'b0;
      in_valid2 = 1'b0;

      // single-digit sweep 0..9
      for (int i = 0; i <= 9; i++) begin
         drive1(1'b1, 4'(i));
         check1($sformatf("sweep%0d", i), 1'b1, 4'(i), 1'b0, 1'b0);
      end

      // invalid codes, then a valid one
      drive1(1'b1, 4'b1010);
      check1("bad_a", 1'b1, 4'd0, 1'b1, 1'b1);
      drive1(1'b1, 4'b1111);
      check1("bad_f", 1'b1, 4'd0, 1'b1, 1'b1);
      drive1(1'b1, 4'd3);
      check1("after_bad", 1'b1, 4'd3, 1'b0, 1'b1);

      // single pulse followed by a gap with toggling data
      drive1(1'b1, 4'd7);
      check1("pulse7", 1'b1, 4'b0111, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         drive1(1'b0, (i % 2 == 0) ? 4'd2 : 4'hC);
         check1($sformatf("gap%0d", i), 1'b0, 4'b0111, 1'b0, 1'b1);
      end

      // two-digit build
      drive2(1'b1, 8'h99);
      check2("d2_99", 1'b1, 7'b1100011, 1'b0, 1'b0);
      drive2(1'b1, 8'h10);
      check2("d2_10", 1'b1, 7'd10, 1'b0, 1'b0);
      drive2(1'b1, 8'h47);
      check2("d2_47", 1'b1, 7'd47, 1'b0, 1'b0);
      drive2(1'b1, 8'h3A);
      check2("d2_3a", 1'b1, 7'd0, 1'b1, 1'b1);
      drive2(1'b1, 8'hA5);
      check2("d2_a5", 1'b1, 7'd0, 1'b1, 1'b1);
      drive2(1'b1, 8'h00);
      check2("d2_00", 1'b1, 7'd0, 1'b0, 1'b1);
      drive2(1'b0, 8'h55);
      check2("d2_idle", 1'b0, 7'd0, 1'b0, 1'b1);

      // reset coinciding with a valid item: the item is discarded
      rst = 1'b1;
      drive1(1'b1, 4'd6);
      check1("rst_mid", 1'b0, 4'd0, 1'b0, 1'b0);
      check2("rst_mid2", 1'b0, 7'd0, 1'b0, 1'b0);
      rst = 1'b0;
      drive1(1'b0, 4'd6);
      check1("post_rst", 1'b0, 4'd0, 1'b0, 1'b0);
      drive1(1'b1, 4'd8);
      check1("post_rst_item", 1'b1, 4'd8, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
